// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the popcount fold sequencer and its scale stage.
package popcount_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StOut} state_e;

  function automatic int unsigned gamma_shift(input int unsigned twidth,
                                              input int unsigned popcount_width,
                                              input int unsigned fixed_point);
    return twidth - popcount_width + fixed_point;
  endfunction

  function automatic int unsigned term_width(input int unsigned popcount_width,
                                             input int unsigned simd_width,
                                             input int unsigned weight_levels);
    return popcount_width + $clog2(simd_width + 1) + $clog2(weight_levels) + 1;
  endfunction

  localparam int unsigned GAMMA_SHIFT = gamma_shift(24, 16, 8);
  localparam int unsigned TERM_WIDTH  = term_width(16, 32, 2);

endpackage

// File: rtl/popcount_fold_ctrl_if.sv
// Beat input stream and result output stream of the popcount fold sequencer.
interface popcount_fold_ctrl_if #(
  parameter int unsigned WEIGHT_LEVELS = 2,
  parameter int unsigned SIMD_WIDTH    = 32,
  parameter int unsigned TWIDTH        = 24,
  parameter int unsigned ACC_WIDTH     = 32
);
  logic                              in_valid;
  logic                              in_ready;
  logic [WEIGHT_LEVELS*SIMD_WIDTH-1:0] in_xnor;
  logic [WEIGHT_LEVELS*TWIDTH-1:0]   in_gamma;
  logic                              out_valid;
  logic                              out_ready;
  logic [ACC_WIDTH-1:0]              out_acc;

  modport master (
    output in_valid, in_xnor, in_gamma, out_ready,
    input  in_ready, out_valid, out_acc
  );

  modport slave (
    input  in_valid, in_xnor, in_gamma, out_ready,
    output in_ready, out_valid, out_acc
  );
endinterface

// File: rtl/popcount_scale_stage.sv
// One-stage pipe: per-level popcount times shifted gamma, summed over levels and registered.
module popcount_scale_stage
  import popcount_pkg::*;
#(
  parameter int unsigned WEIGHT_LEVELS  = 2,
  parameter int unsigned SIMD_WIDTH     = 32,
  parameter int unsigned POPCOUNT_WIDTH = 16,
  parameter int unsigned TWIDTH         = 24,
  parameter int unsigned FIXED_POINT    = 8,
  parameter int unsigned ACC_WIDTH      = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                beat_valid,
  input  logic [WEIGHT_LEVELS*SIMD_WIDTH-1:0] xnor_bits,
  input  logic [WEIGHT_LEVELS*TWIDTH-1:0]     gamma,
  output logic signed [ACC_WIDTH-1:0]         term,
  output logic                                term_valid
);
  localparam int unsigned Shift = gamma_shift(TWIDTH, POPCOUNT_WIDTH, FIXED_POINT);
  localparam int unsigned TermW = term_width(POPCOUNT_WIDTH, SIMD_WIDTH, WEIGHT_LEVELS);
  localparam int unsigned CntW  = $clog2(SIMD_WIDTH + 1);

  logic        [CntW-1:0]           pcnt [WEIGHT_LEVELS];
  logic signed [TWIDTH-1:0]         gsh  [WEIGHT_LEVELS];
  logic signed [POPCOUNT_WIDTH-1:0] wgt  [WEIGHT_LEVELS];
  logic signed [TermW-1:0]          sum;

  always_comb begin
    sum = '0;
    for (int j = 0; j < WEIGHT_LEVELS; j++) begin
      pcnt[j] = '0;
      for (int b = 0; b < SIMD_WIDTH; b++) begin
        pcnt[j] = pcnt[j] + CntW'(xnor_bits[j*SIMD_WIDTH + b]);
      end
      gsh[j] = $signed(gamma[j*TWIDTH +: TWIDTH]) >>> Shift;
      wgt[j] = gsh[j][POPCOUNT_WIDTH-1:0];
      // Popcount is non-negative: zero-extend before the signed multiply.
      sum = sum + $signed(TermW'(pcnt[j])) * TermW'(wgt[j]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      term       <= '0;
      term_valid <= 1'b0;
    end else if (flush) begin
      term       <= '0;
      term_valid <= 1'b0;
    end else begin
      term_valid <= beat_valid;
      if (beat_valid) term <= ACC_WIDTH'(sum);
    end
  end

endmodule

// File: rtl/popcount_fold_ctrl.sv
// Fold sequencer: accepts cfg_folds beats, accumulates scaled popcounts, emits a signed result.
// Define SATURATE_EN to clamp the accumulator instead of wrapping.
module popcount_fold_ctrl
  import popcount_pkg::*;
#(
  parameter int unsigned WEIGHT_LEVELS  = 2,
  parameter int unsigned SIMD_WIDTH     = 32,
  parameter int unsigned POPCOUNT_WIDTH = 16,
  parameter int unsigned TWIDTH         = 24,
  parameter int unsigned FIXED_POINT    = 8,
  parameter int unsigned FOLD_MAX       = 64,
  parameter int unsigned ACC_WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [$clog2(FOLD_MAX+1)-1:0] cfg_folds,
  output logic                          busy,
  output logic                          done,
  popcount_fold_ctrl_if.slave           bus
);
  localparam int unsigned CntW = $clog2(FOLD_MAX + 1);
  localparam int unsigned SumW = ACC_WIDTH + 1;

  state_e                      state_q;
  logic [CntW-1:0]             folds_q;
  logic [CntW-1:0]             fold_cnt_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [SumW-1:0]      sum_w;
  logic signed [ACC_WIDTH-1:0] term;
  logic                        term_valid;
  logic                        beat_acc;
  logic                        busy_q;
  logic                        done_q;
`ifdef SATURATE_EN
  logic                        sat_q;
  logic                        sat_hit;
`endif

  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = (state_q == StOut);
  assign bus.out_acc   = acc_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign beat_acc      = bus.in_valid && (state_q == StAccum);

  popcount_scale_stage #(
    .WEIGHT_LEVELS (WEIGHT_LEVELS),
    .SIMD_WIDTH    (SIMD_WIDTH),
    .POPCOUNT_WIDTH(POPCOUNT_WIDTH),
    .TWIDTH        (TWIDTH),
    .FIXED_POINT   (FIXED_POINT),
    .ACC_WIDTH     (ACC_WIDTH)
  ) u_stage (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .beat_valid(beat_acc),
    .xnor_bits (bus.in_xnor),
    .gamma     (bus.in_gamma),
    .term      (term),
    .term_valid(term_valid)
  );

  always_comb begin
    sum_w = SumW'(acc_q) + SumW'(term);
`ifdef SATURATE_EN
    sat_hit = (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]);
    if (sat_q) begin
      acc_next = acc_q;
    end else if (sat_hit) begin
      acc_next = sum_w[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      acc_next = sum_w[ACC_WIDTH-1:0];
    end
`else
    acc_next = sum_w[ACC_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      folds_q    <= '0;
      fold_cnt_q <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SATURATE_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (term_valid) begin
        acc_q <= acc_next;
`ifdef SATURATE_EN
        sat_q <= sat_q | sat_hit;
`endif
      end
      // Later assignments below override the accumulate on abort/start.
      if (abort) begin
        state_q    <= StIdle;
        busy_q     <= 1'b0;
        acc_q      <= '0;
        fold_cnt_q <= '0;
`ifdef SATURATE_EN
        sat_q      <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              folds_q    <= (cfg_folds == '0) ? CntW'(1) : cfg_folds;
              fold_cnt_q <= '0;
              acc_q      <= '0;
`ifdef SATURATE_EN
              sat_q      <= 1'b0;
`endif
              state_q    <= StAccum;
              busy_q     <= 1'b1;
            end
          end
          StAccum: begin
            if (bus.in_valid) begin
              fold_cnt_q <= fold_cnt_q + CntW'(1);
              if (fold_cnt_q + CntW'(1) == folds_q) state_q <= StDrain;
            end
          end
          StDrain: begin
            state_q <= StOut;
          end
          StOut: begin
            if (bus.out_ready) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_popcount_fold_ctrl.sv
// Scoreboard bench for popcount_fold_ctrl; a second narrow-accumulator instance covers overflow.
`timescale 1ns/1ps
module tb_popcount_fold_ctrl;
  localparam int unsigned WL = 2, SW = 32, PW = 16, TW = 24, FP = 8, FM = 64, AW = 32;
  localparam int unsigned CW = $clog2(FM + 1);
  localparam int unsigned XW = WL * SW, GW = WL * TW;
  // Narrow instance: gamma widened and fraction dropped so a shift of 16 yields w=1000.
  localparam int unsigned TW16 = 32, FP16 = 0, AW16 = 16, GW16 = WL * TW16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, busy, done;
  logic [CW-1:0] cfg_folds = '0;
  logic start16 = 1'b0, abort16 = 1'b0, busy16, done16;
  logic [CW-1:0] cfg16 = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  popcount_fold_ctrl_if #(.WEIGHT_LEVELS(WL), .SIMD_WIDTH(SW), .TWIDTH(TW), .ACC_WIDTH(AW)) bus ();
  popcount_fold_ctrl_if #(.WEIGHT_LEVELS(WL), .SIMD_WIDTH(SW), .TWIDTH(TW16),
                          .ACC_WIDTH(AW16)) bus16 ();

  popcount_fold_ctrl #(
    .WEIGHT_LEVELS(WL), .SIMD_WIDTH(SW), .POPCOUNT_WIDTH(PW), .TWIDTH(TW),
    .FIXED_POINT(FP), .FOLD_MAX(FM), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_folds(cfg_folds),
    .busy(busy), .done(done), .bus(bus)
  );

  popcount_fold_ctrl #(
    .WEIGHT_LEVELS(WL), .SIMD_WIDTH(SW), .POPCOUNT_WIDTH(PW), .TWIDTH(TW16),
    .FIXED_POINT(FP16), .FOLD_MAX(FM), .ACC_WIDTH(AW16)
  ) dut16 (
    .clk(clk), .rst(rst), .start(start16), .abort(abort16), .cfg_folds(cfg16),
    .busy(busy16), .done(done16), .bus(bus16)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  function automatic int term_model(input logic [XW-1:0] x, input logic [GW-1:0] g);
    int s;
    logic signed [TW-1:0] gj;
    logic signed [PW-1:0] wj;
    s = 0;
    for (int j = 0; j < WL; j++) begin
      gj = g[j*TW +: TW];
      wj = PW'(gj >>> (TW - PW + FP));
      s += $countones(x[j*SW +: SW]) * int'(wj);
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int folds);
    cfg_folds = CW'(folds);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit gaps, input bit rnd, input logic [XW-1:0] x,
                      input logic [GW-1:0] g, output bit ok, output int sum);
    int got, cyc;
    bit hole;
    got = 0; cyc = 0; hole = 1'b0; sum = 0;
    bus.in_xnor = x;
    bus.in_gamma = g;
    while (got < n && cyc < 100) begin
      if (rnd) begin
        bus.in_xnor  = {$urandom(), $urandom()};
        bus.in_gamma = GW'({$urandom(), $urandom()});
      end
      bus.in_valid = !(gaps && hole);
      if (bus.in_valid && bus.in_ready) begin
        got++;
        sum += term_model(bus.in_xnor, bus.in_gamma);
      end
      tick();
      hole = !hole;
      cyc++;
    end
    bus.in_valid = 1'b0;
    ok = (got == n);
  endtask

  task automatic wait_out(input int max, output bit seen, output int waited);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < max) begin
      if (bus.out_valid) seen = 1'b1;
      else begin
        tick();
        waited++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++;
    if ({bus.in_ready, bus.out_valid, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {bus.in_ready, bus.out_valid, busy, done});
    end
    n_checks++;
    if (bus.out_acc !== '0) begin
      n_fail++;
      $display("FAIL reset_out_acc: got %0d expected 0", bus.out_acc);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok, seen;
    int s, w, e;
    exp_q.push_back(384);
    do_start(4);
    feed(4, 1'b0, 1'b0, {32'h0, 32'hFFFF_FFFF}, {24'h0, 24'h03_0000}, ok, s);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_feed: got short expected 4 beats"); end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain_in_ready: got %b expected 0", bus.in_ready);
    end
    wait_out(20, seen, w);
    n_checks++;
    if (!seen || w != 1) begin
      n_fail++;
      $display("FAIL basic_out_valid_cycle: got wait %0d expected 1", w);
    end
    e = exp_q.pop_front();
    n_checks++;
    if ($signed(bus.out_acc) !== e) begin
      n_fail++;
      $display("FAIL basic_out_acc: got %0d expected %0d", $signed(bus.out_acc), e);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if ({done, bus.out_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_done_pulse: got %b expected 100", {done, bus.out_valid, busy});
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_clear: got %b expected 0", done); end
  endtask

  task automatic test_mixed();
    bit ok, seen;
    int s, w, e;
    for (int f = 1; f >= 0; f--) begin
      exp_q.push_back(32);
      do_start(f);
      feed(1, 1'b0, 1'b0, {64{1'b1}}, {24'hFE_0000, 24'h03_0000}, ok, s);
      wait_out(20, seen, w);
      n_checks++;
      if (!ok || !seen) begin
        n_fail++;
        $display("FAIL mixed_folds%0d_handshake: got ok=%b seen=%b expected 1 1", f, ok, seen);
      end
      e = exp_q.pop_front();
      n_checks++;
      if ($signed(bus.out_acc) !== e) begin
        n_fail++;
        $display("FAIL mixed_folds%0d_acc: got %0d expected %0d", f, $signed(bus.out_acc), e);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit ok, seen;
    int s, w, e, dones;
    do_start(3);
    feed(3, 1'b1, 1'b1, '0, '0, ok, s);
    exp_q.push_back(s);
    wait_out(20, seen, w);
    n_checks++;
    if (!ok || !seen || w != 1) begin
      n_fail++;
      $display("FAIL bp_latency: got ok=%b seen=%b wait=%0d expected 1 1 1", ok, seen, w);
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || $signed(bus.out_acc) !== e) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b acc=%0d expected v=1 acc=%0d", i, bus.out_valid,
                 $signed(bus.out_acc), e);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      tick();
    end
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_overflow();
    int got, cyc, e;
`ifdef SATURATE_EN
    exp_q.push_back(32767);
`else
    exp_q.push_back(-1536);
`endif
    bus16.in_xnor  = {32'h0, 32'hFFFF_FFFF};
    bus16.in_gamma = {32'h0, 32'(1000 << 16)};
    cfg16 = CW'(2);
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    bus16.in_valid = 1'b1;
    got = 0; cyc = 0;
    while (got < 2 && cyc < 50) begin
      if (bus16.in_ready) got++;
      tick();
      cyc++;
    end
    bus16.in_valid = 1'b0;
    cyc = 0;
    while (!bus16.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (bus16.out_valid !== 1'b1 || int'($signed(bus16.out_acc)) != e) begin
      n_fail++;
      $display("FAIL overflow_acc16: got v=%b acc=%0d expected v=1 acc=%0d", bus16.out_valid,
               $signed(bus16.out_acc), e);
    end
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    bit ok, seen;
    int s, w, e, hits;
    do_start(4);
    feed(2, 1'b0, 1'b0, {32'h0, 32'hFFFF_FFFF}, {24'h0, 24'h03_0000}, ok, s);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy, bus.in_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle: got %b expected 00", {busy, bus.in_ready});
    end
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid || done) hits++;
      tick();
    end
    n_checks++;
    if (hits != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d expected 0", hits); end
    exp_q.push_back(96);
    do_start(1);
    feed(1, 1'b0, 1'b0, {32'h0, 32'hFFFF_FFFF}, {24'h0, 24'h03_0000}, ok, s);
    wait_out(20, seen, w);
    e = exp_q.pop_front();
    n_checks++;
    if (!seen || $signed(bus.out_acc) !== e) begin
      n_fail++;
      $display("FAIL abort_restart_acc: got %0d expected %0d", $signed(bus.out_acc), e);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    int s, w, e, hits;
    do_start(4);
    feed(4, 1'b0, 1'b0, {32'h0, 32'hFFFF_FFFF}, {24'h0, 24'h03_0000}, ok, s);
    rst = 1'b0;
    #2;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, busy, done} !== 4'b0 || bus.out_acc !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %b acc=%0d expected 0000 acc=0",
               {bus.in_ready, bus.out_valid, busy, done}, bus.out_acc);
    end
    tick();
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid || done) hits++;
      tick();
    end
    n_checks++;
    if (hits != 0) begin n_fail++; $display("FAIL reset_mid_quiet: got %0d expected 0", hits); end
    // 96 + 32; a second start honoured mid-run would clear acc and fold count.
    exp_q.push_back(128);
    do_start(2);
    feed(1, 1'b0, 1'b0, {32'h0, 32'hFFFF_FFFF}, {24'h0, 24'h03_0000}, ok, s);
    cfg_folds = CW'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(1, 1'b0, 1'b0, {32'h0, 32'hFFFF_FFFF}, {24'h0, 24'h01_0000}, ok, s);
    wait_out(20, seen, w);
    e = exp_q.pop_front();
    n_checks++;
    if (!seen || $signed(bus.out_acc) !== e) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got %0d expected %0d", $signed(bus.out_acc), e);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL done_cycle: got %b expected 1", done); end
    exp_q.push_back(96);
    do_start(1);
    n_checks++;
    if ({busy, bus.in_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_in_done_cycle: got %b expected 11", {busy, bus.in_ready});
    end
    feed(1, 1'b0, 1'b0, {32'h0, 32'hFFFF_FFFF}, {24'h0, 24'h03_0000}, ok, s);
    wait_out(20, seen, w);
    e = exp_q.pop_front();
    n_checks++;
    if (!seen || $signed(bus.out_acc) !== e) begin
      n_fail++;
      $display("FAIL done_cycle_run_acc: got %0d expected %0d", $signed(bus.out_acc), e);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_xnor = '0;
    bus.in_gamma = '0;
    bus.out_ready = 1'b0;
    bus16.in_valid = 1'b0;
    bus16.in_xnor = '0;
    bus16.in_gamma = '0;
    bus16.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_mixed();
    test_backpressure();
    test_overflow();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/popcount_fold_ctrl.md
# popcount_fold_ctrl

Sequencer for the binarized multi-level dot-product datapath. It accepts a stream of XNOR result words and per-level gamma scales over a configurable number of folds, and forms the gamma-weighted per-level popcount of each beat in a one-stage pipelined sub-block. It accumulates the folds into a signed sum and hands the result downstream with a valid/ready handshake. It sits between the weight/activation fetch logic and the threshold/activation stage of a matrix-vector unit.

## Interface
- WEIGHT_LEVELS, 2, number of binary weight levels per beat
- SIMD_WIDTH, 32, XNOR bits per level per beat
- POPCOUNT_WIDTH, 16, signed width of scaled gamma and per-level product
- TWIDTH, 24, signed width of each gamma field
- FIXED_POINT, 8, fractional bits removed from gamma
- FOLD_MAX, 64, maximum beats per dot product
- ACC_WIDTH, 32, signed accumulator/result width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  begin a dot product; sampled only in IDLE
- abort  in  1  synchronous cancel; any state returns to IDLE
- cfg_folds  in  $clog2(FOLD_MAX+1)  beats for this dot product, latched on start
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_xnor  in  WEIGHT_LEVELS*SIMD_WIDTH  level j at bits [j*SIMD_WIDTH +: SIMD_WIDTH]
- in_gamma  in  WEIGHT_LEVELS*TWIDTH  signed gamma j at [j*TWIDTH +: TWIDTH]
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accept
- out_acc  out  ACC_WIDTH  signed result, stable while out_valid
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the result handshake

## Operation
- FSM states: IDLE, ACCUM, DRAIN, OUT.
- IDLE: in_ready=0. On start, latch cfg_folds (0 is treated as 1), clear acc and fold_cnt, and go to ACCUM. start outside IDLE is ignored.
- ACCUM: in_ready=1. Each accepted beat is sent to the stage and increments fold_cnt. On acceptance of beat number cfg_folds, go to DRAIN with in_ready=0 from that next cycle.
- Stage, per level j:
  - p_j = popcount of the level-j slice, in the range 0..SIMD_WIDTH.
  - w_j = gamma_j >>> (TWIDTH-POPCOUNT_WIDTH+FIXED_POINT), arithmetic shift, truncated to POPCOUNT_WIDTH signed.
  - term = Σ p_j*w_j at full width, sign-extended to ACC_WIDTH, registered together with term_valid.
- acc += term on every cycle term_valid=1.
- DRAIN: one cycle for the last term to land, then go to OUT.
- OUT: out_valid=1 and out_acc=acc. On out_valid & out_ready, go to IDLE and pulse done in the following cycle. A start sampled in that done cycle is accepted.
- abort: clears term_valid, acc, fold_cnt, out_valid; next state IDLE; no done. abort takes priority over start and over handshakes in the same cycle.
- Beats offered outside ACCUM are not accepted (in_ready=0).

## Timing
- Reset values: in_ready=0, out_valid=0, out_acc=0, busy=0, done=0; FSM=IDLE; acc, fold_cnt, term_valid=0.
- Reset asserted mid-operation discards all work. No done and no out_valid after release.
- start in cycle 0 gives in_ready=1 from cycle 1. With N folds and no input gaps, beats are accepted in cycles 1..N, DRAIN is cycle N+2-1=N+1, and out_valid rises in cycle N+2.
- Each input gap delays out_valid by one cycle.
- All outputs are registered except in_ready and out_valid, which are decoded from the FSM state register only.

## Configuration
- SATURATE_EN defined: each accumulate clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], and stays clamped for the rest of the dot product.
- SATURATE_EN undefined: two's-complement wrap at ACC_WIDTH.

## Structure
- Shared package popcount_pkg holds:
  - the FSM state enum;
  - GAMMA_SHIFT = TWIDTH-POPCOUNT_WIDTH+FIXED_POINT;
  - TERM_WIDTH = POPCOUNT_WIDTH+$clog2(SIMD_WIDTH+1)+$clog2(WEIGHT_LEVELS)+1.
- One sub-module, popcount_scale_stage: per-level popcount, gamma shift, multiply, level sum, and the output register with term_valid.

## Test plan
Defaults unless stated; shift=16.
- Basic sum: gamma0=3<<16, gamma1=0, xnor level0 all ones, level1 zero, cfg_folds=4, continuous beats -> out_valid in cycle 6, out_acc=384, done one cycle after out_ready.
- Mixed sign: gamma0=3<<16, gamma1=-(2<<16), both levels all ones, cfg_folds=1 -> out_acc=32. Same stimulus with cfg_folds=0 -> identical result.
- Backpressure: cfg_folds=3, in_valid low every other cycle, out_ready low for 5 cycles -> out_acc stable and out_valid held throughout; exactly one done pulse.
- Overflow, ACC_WIDTH=16: gamma0=1000<<16, level0 all ones, cfg_folds=2 -> out_acc=32767 with SATURATE_EN, -1536 without.
- Abort: abort after 2 of 4 beats -> IDLE next cycle, no out_valid, no done. A following start with 1 beat of term 96 -> out_acc=96.
- Reset mid-operation: rst low during DRAIN -> all outputs 0 immediately. After release, start while busy is ignored, and start in the done cycle is accepted.
